// File: rtl/nrzi_rx.sv
// nrzi_rx: NRZI line receiver with sync detection, byte assembly and framing.
// A decoded 1 means "no transition", a decoded 0 means "transition".
// Optional feature macro NRZI_RX_STUFF_EN: bit-unstuffing after six 1s and
// stuff-error detection. Without it every decoded bit is payload data.
module nrzi_rx (
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  input  logic       in_valid,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       sop,
  output logic       eop,
  output logic       err,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_ERROR = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        prev_q, prev_d;
  logic [7:0]  sync_q, sync_d;
  logic [2:0]  fill_q, fill_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        data_valid_q, data_valid_d;
  logic        sop_q, sop_d;
  logic        eop_q, eop_d;
  logic        err_q, err_d;
  logic        dbit;
  logic        stuff_pending;

`ifdef NRZI_RX_STUFF_EN
  logic [2:0]  ones_q, ones_d;
  assign stuff_pending = (ones_q == 3'd6);
`else
  assign stuff_pending = 1'b0;
`endif

  // NRZI decode against the previous sampled level
  assign dbit = (in == prev_q);

  // Next-state, datapath and event-pulse logic
  always_comb begin
    state_d      = state_q;
    prev_d       = in_valid ? in : 1'b1;
    sync_d       = sync_q;
    fill_d       = fill_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    sop_d        = 1'b0;
    eop_d        = 1'b0;
    err_d        = 1'b0;
`ifdef NRZI_RX_STUFF_EN
    ones_d       = ones_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sync_d = {sync_q[6:0], dbit};
          if (fill_q != 3'd7) fill_d = fill_q + 3'd1;
          // fill_q guards against a short history after idle/reset looking
          // like seven received zeros
          if ((fill_q == 3'd7) && (sync_d == 8'h01)) begin
            state_d   = ST_DATA;
            sop_d     = 1'b1;
            sync_d    = '0;
            fill_d    = '0;
            bit_cnt_d = '0;
`ifdef NRZI_RX_STUFF_EN
            ones_d    = 3'd1;
`endif
          end
        end else begin
          sync_d = '0;
          fill_d = '0;
        end
      end
      ST_DATA: begin
        if (in_valid) begin
          if (stuff_pending) begin
            if (dbit) begin
              err_d     = 1'b1;
              state_d   = ST_ERROR;
              bit_cnt_d = '0;
            end
`ifdef NRZI_RX_STUFF_EN
            ones_d = '0;
`endif
          end else begin
            shift_d   = {dbit, shift_q[6:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              data_out_d   = {dbit, shift_q};
              data_valid_d = 1'b1;
            end
`ifdef NRZI_RX_STUFF_EN
            ones_d = dbit ? ones_q + 3'd1 : 3'd0;
`endif
          end
        end else begin
          if ((bit_cnt_q == 3'd0) && !stuff_pending) eop_d = 1'b1;
          else                                      err_d = 1'b1;
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
`ifdef NRZI_RX_STUFF_EN
          ones_d    = '0;
`endif
        end
      end
      ST_ERROR: begin
        if (!in_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      prev_q       <= 1'b1;
      sync_q       <= '0;
      fill_q       <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      err_q        <= 1'b0;
`ifdef NRZI_RX_STUFF_EN
      ones_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      sync_q       <= sync_d;
      fill_q       <= fill_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      sop_q        <= sop_d;
      eop_q        <= eop_d;
      err_q        <= err_d;
`ifdef NRZI_RX_STUFF_EN
      ones_q       <= ones_d;
`endif
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign sop        = sop_q;
  assign eop        = eop_q;
  assign err        = err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: doc/nrzi_rx.md
NRZI_RX -- requirements
Module: nrzi_rx

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, ports as follows:
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in  input  1  NRZI line level, sampled only when in_valid=1.
REQ-005 in_valid  input  1  sample strobe; low means the line is idle or the packet has ended.
REQ-006 data_out  output  8  received byte, LSB received first.
REQ-007 data_valid  output  1  one-cycle pulse qualifying data_out.
REQ-008 sop  output  1  one-cycle pulse on sync detect.
REQ-009 eop  output  1  one-cycle pulse on clean packet end.
REQ-010 err  output  1  one-cycle pulse on stuff error or frame error.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 NRZI decode SHALL work as follows: decoded bit = 1 when the sampled in equals prev_level, and 0 when it differs; prev_level updates on every valid sample and is forced to 1 whenever in_valid=0.
REQ-013 States SHALL be IDLE, DATA and ERROR, encoded in 2 bits.
REQ-014 In IDLE, the last 8 decoded bits SHALL be shifted in; receipt of seven 0s followed by one 1 SHALL transition to DATA and pulse sop on the next cycle.
REQ-015 The IDLE sync shift register SHALL clear whenever in_valid=0.
REQ-016 In DATA, decoded bits SHALL be assembled LSB-first into a byte using a 3-bit bit counter.
REQ-017 On the 8th accepted bit, data_out SHALL update and data_valid SHALL pulse on the next cycle (latency 1); the counter SHALL wrap to 0.
REQ-018 data_out SHALL hold its value between pulses.
REQ-019 A ones counter SHALL count consecutive decoded 1s and SHALL be set to 1 on entering DATA, because the final sync bit counts.
REQ-020 After six consecutive 1s, the next valid sample is a stuff bit: a decoded 0 SHALL be discarded and clear the counter.
REQ-021 A decoded 1 in the stuff-bit position SHALL pulse err and transition to ERROR.
REQ-022 A stuff bit SHALL NOT advance the bit counter.
REQ-023 If in_valid=0 in DATA with bit counter=0 and no stuff bit pending, the block SHALL pulse eop and return to IDLE.
REQ-024 If in_valid=0 in DATA otherwise, the block SHALL pulse err (frame error) and return to IDLE, discarding the partial byte.
REQ-025 ERROR SHALL ignore samples and return to IDLE on the first cycle with in_valid=0.
REQ-026 sop, eop, err and data_valid SHALL each be registered and high for exactly one clk cycle per event.
REQ-027 If a byte completes on the same cycle in_valid falls, data_valid SHALL pulse and eop SHALL follow on the next cycle.

Reset
REQ-028 While reset=1: state=IDLE, prev_level=1, all counters and the sync shift register=0, data_out=8'h00, data_valid=sop=eop=err=busy=0.
REQ-029 Reset SHALL take priority over every other event, including mid-packet, and no eop or err SHALL be emitted for a packet aborted by reset.
REQ-030 The first sample after reset deasserts SHALL be decoded against prev_level=1.

Configuration
REQ-031 With macro NRZI_RX_STUFF_EN defined, bit-unstuffing and stuff-error detection (REQ-019..REQ-022) SHALL be compiled in.
REQ-032 Without NRZI_RX_STUFF_EN, no ones counter SHALL exist; every decoded bit SHALL be data, and err SHALL fire only for frame errors.

Verification
REQ-033 Sync plus byte: in_valid=1, line 0,1,0,1,0,1,0,0 then 0,1,1,0,1,1,0,0, then in_valid=0 -> sop once, data_valid once with data_out=8'hA5, then eop, busy returns to 0.
REQ-034 Stuffing: sync, then eight decoded 1s with a stuffed 0 after the 5th data 1 -> data_out=8'hFF, one data_valid, err=0 (with NRZI_RX_STUFF_EN).
REQ-035 Stuff error: sync, then five data 1s followed by a 1 in the stuff-bit position -> err pulse, state ERROR, no data_valid; IDLE after in_valid=0.
REQ-036 Frame error: sync, then 5 data bits, then in_valid=0 -> err pulse, no eop, no data_valid, busy=0 one cycle later.
REQ-037 Reset mid-packet: assert reset after 4 data bits -> next cycle all outputs 0, state IDLE; a new sync+8'h3C packet then decodes correctly.
REQ-038 Noise: 7 zeros then a 0 (no terminating 1), then in_valid=0 -> no sop, busy stays 0.
